// File: rtl/conv2d3x3_pkg.sv
// Shared constants for the conv2d3x3 pixel-stream blocks: FSM encoding and frame-size helpers.
package conv2d3x3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int IMG_SIZE_DEFAULT = 100;
   localparam int IMG_PIXELS       = IMG_SIZE_DEFAULT * IMG_SIZE_DEFAULT;

   function automatic int img_pixels(input int side);
      return side * side;
   endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO with occupancy count; push and pop may happen in the same cycle.
module stream_fifo2 #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_count
);

   logic [DATA_WIDTH-1:0] r_mem [2];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic                  w_push;
   logic                  w_pop;

   assign w_pop  = i_pop & (r_count != 2'd0);
   assign w_push = i_push & ((r_count != 2'd2) | w_pop);

   // Storage, pointers and occupancy.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/conv_pixel_streamer.sv
// Reads an IMG_SIZE x IMG_SIZE frame from synchronous-read memory in raster order and
// streams it over valid/ready, tagging the head pixel's last-column / last-pixel position.
module conv_pixel_streamer
   import conv2d3x3_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14,
   parameter int IMG_SIZE   = 100
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Start,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Mem_Rd_En,
   output logic [ADDR_WIDTH-1:0] Mem_Addr,
   input  logic [DATA_WIDTH-1:0] Mem_Data,
   output logic [DATA_WIDTH-1:0] Pixel_Out,
   output logic                  Pixel_Valid,
   input  logic                  Pixel_Ready,
   output logic                  Pixel_Last_Col,
   output logic                  Pixel_Last
);

   localparam int                    PIXELS    = img_pixels(IMG_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);
   localparam int                    CW        = $clog2(IMG_SIZE);
   localparam logic [CW-1:0]         LAST_POS  = CW'(IMG_SIZE - 1);

   state_e                r_state;
   state_e                w_next;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_inflight;
   logic [CW-1:0]         r_col;
   logic [CW-1:0]         r_row;
   logic [1:0]            w_count;
   logic                  w_pop;
   logic [2:0]            w_commit;

   assign w_pop       = Pixel_Valid & Pixel_Ready;
   assign Pixel_Valid = (w_count != 2'd0);
   // Slots already promised: FIFO contents plus the word returning this cycle, less what leaves now.
   assign w_commit    = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   // FSM state register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (Start) w_next = ST_READ; else w_next = ST_IDLE;
         ST_READ:  if (Mem_Rd_En && (r_rd_addr == LAST_ADDR)) w_next = ST_DRAIN; else w_next = ST_READ;
         ST_DRAIN: if (w_pop && Pixel_Last) w_next = ST_DONE; else w_next = ST_DRAIN;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // FSM outputs; reads are issued only while a FIFO slot is guaranteed free on return.
   always_comb begin
      Busy      = 1'b0;
      Done      = 1'b0;
      Mem_Rd_En = 1'b0;
      case (r_state)
         ST_READ: begin
            Busy      = 1'b1;
            Mem_Rd_En = (w_commit < 3'd2);
         end
         ST_DRAIN: Busy = 1'b1;
         ST_DONE:  Done = 1'b1;
         default:  Busy = 1'b0;
      endcase
   end

   // Read address, returning-read flag and head-pixel position counters.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_rd_addr  <= '0;
         r_inflight <= 1'b0;
         r_col      <= '0;
         r_row      <= '0;
      end else begin
         r_inflight <= Mem_Rd_En;
         if (r_state == ST_DONE) begin
            r_rd_addr <= '0;
         end else if (Mem_Rd_En && (r_rd_addr != LAST_ADDR)) begin
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
         end
         if (w_pop) begin
            if (r_col == LAST_POS) begin
               r_col <= '0;
               r_row <= (r_row == LAST_POS) ? '0 : r_row + CW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
         end
      end
   end

   stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .Clk     (Clk),
      .Rst     (Rst),
      .i_push  (r_inflight),
      .i_data  (Mem_Data),
      .i_pop   (w_pop),
      .o_data  (Pixel_Out),
      .o_count (w_count)
   );

   assign Mem_Addr       = r_rd_addr;
   assign Pixel_Last_Col = (r_col == LAST_POS) & Pixel_Valid;
   assign Pixel_Last     = Pixel_Last_Col & (r_row == LAST_POS);

endmodule
